wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter sitting directly upstream of the general-purpose register file. It merges single-cycle ALU results and long-latency load/mul results into the register file's single write port (`rd_w`, `rd_addr`, `rd`). A 2-entry buffer absorbs long-latency results while the ALU holds the port. A scoreboard of pending long-latency destinations lets decode stall on RAW hazards.

## Interface
Parameters:
- `XLEN`, 32, data width.
- `AW`, 5, register address width (32 registers).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `alu_v`  in  1  ALU result valid; always accepted, no backpressure.
- `alu_addr`  in  AW  ALU destination.
- `alu_data`  in  XLEN  ALU result.
- `lsu_valid`  in  1  long-latency result valid.
- `lsu_ready`  out  1  buffer can accept a result.
- `lsu_addr`  in  AW  long-latency destination.
- `lsu_data`  in  XLEN  long-latency result.
- `iss_v`  in  1  long-latency op issued this cycle.
- `iss_addr`  in  AW  destination of the issued op.
- `chk_addr1`, `chk_addr2`  in  AW  decode source addresses.
- `busy1`, `busy2`  out  1  the matching source has a pending long-latency write.
- `rd_w`  out  1  register-file write enable.
- `rd_addr`  out  AW  register-file write address.
- `rd`  out  XLEN  register-file write data.
- `buf_cnt`  out  2  buffer occupancy (0–2).

## Operation
- Long-latency buffer:
  - 2-entry FIFO of {addr, data}.
  - Push when `lsu_valid && lsu_ready`.
  - `lsu_ready = (buf_cnt != 2)`, combinational from the registered count.
- Arbitration each cycle:
  - If `alu_v`, the ALU wins.
  - Otherwise, if `buf_cnt != 0`, the FIFO head wins and is popped.
  - Otherwise the port is idle.
- Output register, loaded every edge from the winner:
  - `rd_w <= winner_valid && winner_addr != 0`.
  - `rd_addr` and `rd` are loaded only when a winner exists; otherwise they hold.
  - A registered source flag `src_lsu` records whether the winner was the buffer.
- x0: writes to address 0 never assert `rd_w`. A buffer entry with addr 0 is still popped.
- Scoreboard: 32 bits `sb`.
  - Set `sb[iss_addr]` on `iss_v && iss_addr != 0`.
  - Clear `sb[rd_addr]` on the edge where `rd_w && src_lsu`, i.e. the edge the register file writes.
  - Set and clear of the same address on the same edge: set wins.
- `busy1 = sb[chk_addr1]` and `busy2 = sb[chk_addr2]`, both combinational. `busy` is always 0 for address 0.
- ALU writes never touch the scoreboard. WAW ordering between ALU and long-latency ops is the issuer's responsibility.
- The ALU can starve the buffer indefinitely. `lsu_ready` stays low while the buffer is full.

## Timing
- Reset values:
  - `rd_w=0`, `rd_addr=0`, `rd=0`, `src_lsu=0`.
  - `buf_cnt=0`, so `lsu_ready=1`.
  - `sb=0`, so `busy1=busy2=0`.
- ALU latency: `alu_v` sampled at edge N → `rd_w` high after N → register file written at N+1.
- LSU latency with the buffer empty and no ALU: accepted at edge N → output loaded at N+1 → register file written at N+2; `busy` drops after N+2.
- Each ALU cycle adds one cycle of delay to a queued LSU entry.
- Push and pop on the same edge: count unchanged, FIFO order preserved.
- Full (`buf_cnt=2`): `lsu_ready=0`. A `lsu_valid` held by the producer is accepted on the first edge after a pop.
- Reset mid-operation: buffer contents and pending scoreboard bits are discarded immediately. `rd_w` drops asynchronously.

## Configuration
- `WB_SCOREBOARD_EN`:
  - Defined: scoreboard behaves as above.
  - Undefined: no `sb` storage; `busy1=busy2=0` constantly; `iss_v` and `iss_addr` are ignored. All other behaviour is identical.

## Structure
- Package `wb_pkg`:
  - Constants `XLEN=32`, `AW=5`, `NREG=32`.
  - Typedef `wb_entry_t` = {addr, data}.
  - Enum `wb_src_e` {`SRC_NONE`, `SRC_ALU`, `SRC_LSU`}.
- Sub-module `wb_fifo2`: 2-entry FIFO with push/pop/count. It is instantiated once for the long-latency buffer.

## Test plan
- Reset, then `alu_v=1`, `alu_addr=5`, `alu_data=0x1234` for one cycle → next cycle `rd_w=1`, `rd_addr=5`, `rd=0x1234`; `rd_w=0` the cycle after.
- `iss_v` with addr 7; `chk_addr1=7` → `busy1=1`. Push LSU {7, 0xAA} → `rd_w` with 0xAA two edges after accept; `busy1=0` after the write edge.
- Hold `alu_v` for 4 cycles while pushing 3 LSU results {1,11}, {2,22}, {3,33} → `lsu_ready=0` once `buf_cnt=2`. After the ALU stops, writes appear in order 11, 22, 33 with no loss.
- ALU to x0, and LSU {0, 0xFF} → `rd_w` never asserts; `buf_cnt` returns to 0.
- `iss_v` to addr 9 on the same edge as an LSU retire to addr 9 → `busy` for 9 stays 1.
- Fill the buffer to 2, assert `rst_n=0` mid-cycle → `rd_w`, `buf_cnt`, `busy` clear immediately; after release, `lsu_ready=1`.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter slice.
package wb_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LSU
  } wb_src_e;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry FIFO; slot 0 is always the head, so a pop shifts slot 1 down.
module wb_fifo2 #(
  parameter type entry_t = wb_pkg::wb_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  entry_t     din,
  input  logic       pop,
  output entry_t     dout,
  output logic [1:0] cnt
);

  entry_t     slot_q [2];
  logic [1:0] cnt_q;
  logic       wr_idx;

  // Slot that receives a push, after accounting for a same-edge pop.
  always_comb begin
    wr_idx = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && !pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 2'd0;
      slot_q[0] <= '0;
      slot_q[1] <= '0;
    end else begin
      if (pop) begin
        slot_q[0] <= slot_q[1];
      end
      if (push) begin
        slot_q[wr_idx] <= din;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout = slot_q[0];
  assign cnt  = cnt_q;

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU and long-latency results onto the register-file write port.
// Optional RAW scoreboard enabled by defining WB_SCOREBOARD_EN.
module wb_arbiter #(
  parameter int unsigned XLEN = wb_pkg::XLEN,
  parameter int unsigned AW   = wb_pkg::AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_v,
  input  logic [AW-1:0]   alu_addr,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_addr,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            iss_v,
  input  logic [AW-1:0]   iss_addr,
  input  logic [AW-1:0]   chk_addr1,
  input  logic [AW-1:0]   chk_addr2,
  output logic            busy1,
  output logic            busy2,
  output logic            rd_w,
  output logic [AW-1:0]   rd_addr,
  output logic [XLEN-1:0] rd,
  output logic [1:0]      buf_cnt
);

  import wb_pkg::*;

  wb_entry_t       push_entry;
  wb_entry_t       head;
  logic [1:0]      cnt;
  logic            push;
  logic            pop;
  wb_src_e         win_src;
  logic [AW-1:0]   win_addr;
  logic [XLEN-1:0] win_data;

  logic            rd_w_q;
  logic [AW-1:0]   rd_addr_q;
  logic [XLEN-1:0] rd_q;
  logic            src_lsu_q;

  assign push_entry = '{addr: lsu_addr, data: lsu_data};
  assign lsu_ready  = (cnt != 2'd2);
  assign push       = lsu_valid && lsu_ready;
  assign pop        = (win_src == SRC_LSU);

  wb_fifo2 #(
    .entry_t(wb_entry_t)
  ) u_buf (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .din  (push_entry),
    .pop  (pop),
    .dout (head),
    .cnt  (cnt)
  );

  // ALU has strict priority; the buffer only drains on ALU-idle cycles.
  always_comb begin
    win_src  = SRC_NONE;
    win_addr = alu_addr;
    win_data = alu_data;
    if (alu_v) begin
      win_src = SRC_ALU;
    end else if (cnt != 2'd0) begin
      win_src  = SRC_LSU;
      win_addr = head.addr;
      win_data = head.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_w_q    <= 1'b0;
      rd_addr_q <= '0;
      rd_q      <= '0;
      src_lsu_q <= 1'b0;
    end else begin
      rd_w_q    <= (win_src != SRC_NONE) && (win_addr != '0);
      src_lsu_q <= (win_src == SRC_LSU);
      if (win_src != SRC_NONE) begin
        rd_addr_q <= win_addr;
        rd_q      <= win_data;
      end
    end
  end

  assign rd_w    = rd_w_q;
  assign rd_addr = rd_addr_q;
  assign rd      = rd_q;
  assign buf_cnt = cnt;

`ifdef WB_SCOREBOARD_EN
  logic [NREG-1:0] sb_q;
  logic [NREG-1:0] sb_d;

  // Clear on the register-file write edge; a same-edge reissue must win.
  always_comb begin
    sb_d = sb_q;
    if (rd_w_q && src_lsu_q) begin
      sb_d[rd_addr_q] = 1'b0;
    end
    if (iss_v && (iss_addr != '0)) begin
      sb_d[iss_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  assign busy1 = sb_q[chk_addr1];
  assign busy2 = sb_q[chk_addr2];
`else
  logic unused_sb;
  assign unused_sb = ^{iss_v, iss_addr, chk_addr1, chk_addr2, src_lsu_q};
  assign busy1     = 1'b0;
  assign busy2     = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios then random traffic vs a queue model.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_v;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        iss_v;
  logic [4:0]  iss_addr;
  logic [4:0]  chk_addr1;
  logic [4:0]  chk_addr2;
  logic        busy1;
  logic        busy2;
  logic        rd_w;
  logic [4:0]  rd_addr;
  logic [31:0] rd;
  logic [1:0]  buf_cnt;

  wb_arbiter #(
    .XLEN(32),
    .AW  (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu_v    (alu_v),
    .alu_addr (alu_addr),
    .alu_data (alu_data),
    .lsu_valid(lsu_valid),
    .lsu_ready(lsu_ready),
    .lsu_addr (lsu_addr),
    .lsu_data (lsu_data),
    .iss_v    (iss_v),
    .iss_addr (iss_addr),
    .chk_addr1(chk_addr1),
    .chk_addr2(chk_addr2),
    .busy1    (busy1),
    .busy2    (busy2),
    .rd_w     (rd_w),
    .rd_addr  (rd_addr),
    .rd       (rd),
    .buf_cnt  (buf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [4:0]  addr;
    bit [31:0] data;
  } ent_t;

  // Reference model: pending results as a queue, outstanding destinations as a bit set.
  ent_t      q[$];
  bit [31:0] pend;
  bit        m_w;
  bit [4:0]  m_addr;
  bit [31:0] m_data;
  bit        m_lsu;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_busy(input logic [4:0] a);
`ifdef WB_SCOREBOARD_EN
    return pend[a];
`else
    return pend[a] & 1'b0;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    pend   = '0;
    m_w    = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_lsu  = 1'b0;
  endtask

  task automatic model_step();
    bit        win;
    bit        from_lsu;
    bit        acc;
    bit [4:0]  wa;
    bit [31:0] wd;
    ent_t      e;
    acc = lsu_valid && (q.size() < 2);
    if (m_w && m_lsu) pend[m_addr] = 1'b0;
    if (iss_v && iss_addr != 0) pend[iss_addr] = 1'b1;
    win = 1'b0;
    from_lsu = 1'b0;
    wa = '0;
    wd = '0;
    if (alu_v) begin
      win = 1'b1;
      wa  = alu_addr;
      wd  = alu_data;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      win = 1'b1;
      from_lsu = 1'b1;
      wa = e.addr;
      wd = e.data;
    end
    if (acc) q.push_back('{addr: lsu_addr, data: lsu_data});
    m_w   = win && (wa != 0);
    m_lsu = from_lsu;
    if (win) begin
      m_addr = wa;
      m_data = wd;
    end
  endtask

  task automatic step();
    check_eq("lsu_ready", lsu_ready, q.size() < 2);
    check_eq("busy1", busy1, exp_busy(chk_addr1));
    check_eq("busy2", busy2, exp_busy(chk_addr2));
    @(posedge clk);
    model_step();
    #1;
    check_eq("rd_w", rd_w, m_w);
    check_eq("rd_addr", rd_addr, m_addr);
    check_eq("rd", rd, m_data);
    check_eq("buf_cnt", buf_cnt, q.size());
  endtask

  task automatic idle_inputs();
    alu_v     = 1'b0;
    alu_addr  = '0;
    alu_data  = '0;
    lsu_valid = 1'b0;
    lsu_addr  = '0;
    lsu_data  = '0;
    iss_v     = 1'b0;
    iss_addr  = '0;
  endtask

  initial begin
    int        idx;
    int        got[$];
    bit [31:0] vals[3];
    vals = '{32'd11, 32'd22, 32'd33};

    idle_inputs();
    chk_addr1 = 5'd0;
    chk_addr2 = 5'd0;
    rst_n = 1'b0;
    model_reset();
    #2;
    check_eq("rst_rd_w", rd_w, 0);
    check_eq("rst_rd_addr", rd_addr, 0);
    check_eq("rst_rd", rd, 0);
    check_eq("rst_buf_cnt", buf_cnt, 0);
    check_eq("rst_lsu_ready", lsu_ready, 1);
    check_eq("rst_busy1", busy1, 0);
    check_eq("rst_busy2", busy2, 0);
    #5 rst_n = 1'b1;
    #1;

    // ALU single write
    alu_v = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234;
    step();
    check_eq("alu_rd_w", rd_w, 1);
    check_eq("alu_rd_addr", rd_addr, 5);
    check_eq("alu_rd", rd, 32'h1234);
    idle_inputs();
    step();
    check_eq("alu_rd_w_drop", rd_w, 0);

    // Issue to x7, then retire it through the buffer
    iss_v = 1'b1; iss_addr = 5'd7; chk_addr1 = 5'd7;
    step();
    idle_inputs();
`ifdef WB_SCOREBOARD_EN
    check_eq("busy_after_issue", busy1, 1);
`endif
    lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'hAA;
    step();
    idle_inputs();
    check_eq("lsu_not_yet", rd_w, 0);
    step();
    check_eq("lsu_rd_w", rd_w, 1);
    check_eq("lsu_rd", rd, 32'hAA);
    step();
    check_eq("busy_after_write", busy1, 0);
    step();

    // ALU holds the port while three LSU results queue up
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      bit acc;
      alu_v = 1'b1; alu_addr = 5'(20 + c); alu_data = 32'(c);
      lsu_valid = (idx < 3);
      lsu_addr  = 5'(idx + 1);
      lsu_data  = (idx < 3) ? vals[idx] : 32'd0;
      if (c == 2) check_eq("full_ready", lsu_ready, 0);
      acc = lsu_valid && lsu_ready;
      step();
      if (acc) idx++;
    end
    alu_v = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bit acc;
      lsu_valid = (idx < 3);
      lsu_addr  = 5'(idx + 1);
      lsu_data  = (idx < 3) ? vals[idx] : 32'd0;
      acc = lsu_valid && lsu_ready;
      step();
      if (acc) idx++;
      if (rd_w && rd_addr >= 5'd1 && rd_addr <= 5'd3) got.push_back(int'(rd));
    end
    idle_inputs();
    check_eq("order_count", got.size(), 3);
    for (int i = 0; i < 3; i++) check_eq("order_val", (i < got.size()) ? got[i] : -1, vals[i]);

    // x0 writes never assert rd_w
    alu_v = 1'b1; alu_addr = 5'd0; alu_data = 32'h55;
    step();
    check_eq("x0_alu", rd_w, 0);
    idle_inputs();
    lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 32'hFF;
    step();
    idle_inputs();
    step();
    check_eq("x0_lsu", rd_w, 0);
    step();
    check_eq("x0_drained", buf_cnt, 0);

    // Reissue to x9 on the edge that retires x9
    iss_v = 1'b1; iss_addr = 5'd9; chk_addr1 = 5'd9;
    step();
    idle_inputs();
    lsu_valid = 1'b1; lsu_addr = 5'd9; lsu_data = 32'h99;
    step();
    idle_inputs();
    step();
    check_eq("retire_loaded", rd_w, 1);
    iss_v = 1'b1; iss_addr = 5'd9;
    step();
    idle_inputs();
`ifdef WB_SCOREBOARD_EN
    check_eq("set_wins", busy1, 1);
`endif
    step();

    // Asynchronous reset with a full buffer and a pending destination
    iss_v = 1'b1; iss_addr = 5'd4; chk_addr1 = 5'd4;
    alu_v = 1'b1; alu_addr = 5'd12; alu_data = 32'hC0;
    lsu_valid = 1'b1; lsu_addr = 5'd4; lsu_data = 32'h44;
    step();
    iss_v = 1'b0;
    lsu_addr = 5'd5; lsu_data = 32'h45;
    step();
    idle_inputs();
    check_eq("pre_rst_cnt", buf_cnt, 2);
    check_eq("pre_rst_rd_w", rd_w, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rd_w", rd_w, 0);
    check_eq("mid_rst_cnt", buf_cnt, 0);
    check_eq("mid_rst_busy", busy1, 0);
    model_reset();
    #1 rst_n = 1'b1;
    #1;
    check_eq("post_rst_ready", lsu_ready, 1);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      alu_v     = ($urandom_range(0, 9) < 5);
      alu_addr  = 5'($urandom_range(0, 7));
      alu_data  = $urandom();
      lsu_valid = ($urandom_range(0, 9) < 6);
      lsu_addr  = 5'($urandom_range(0, 7));
      lsu_data  = $urandom();
      iss_v     = ($urandom_range(0, 9) < 3);
      iss_addr  = 5'($urandom_range(0, 7));
      chk_addr1 = 5'($urandom_range(0, 7));
      chk_addr2 = 5'($urandom_range(0, 31));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
